decode_stage_v2: RTL and testbench
==================================

Name: decode_stage_v2

Overview:
- Registered, handshaked successor to the combinational main decoder; sits between fetch and execute.
- Decodes one RV32I/M instruction per accepted beat into the standard 15-bit control bundle.
- Stalls multi-cycle MUL/DIV for a parametrised latency.
- Supports pipeline flush and a one-entry output register with valid/ready on both sides.

Parameters:
- MUL_CYCLES, 2, cycles from accept to out_valid for MUL* (funct3[2]=0), ≥1
- DIV_CYCLES, 16, cycles from accept to out_valid for DIV/REM* (funct3[2]=1), ≥1
- M_EXT, 1, 1 = decode funct7=0000001 OP as M-extension; 0 = treat as base arithmetic

Ports:
- clk, input, 1, system clock
- reset, input, 1, synchronous active-high reset
- flush, input, 1, discard held/pending instruction
- in_valid, input, 1, instr valid
- in_ready, output, 1, stage can accept
- instr, input, 32, instruction word (opcode [6:0], funct3 [14:12], funct7 [31:25])
- out_valid, output, 1, control bundle valid
- out_ready, input, 1, execute accepts bundle
- RegWrite, ALUSrc, ALUOp, ALUAdd, StoreOp, LoadOp, ResultSrc, Branch, output, 1 each, controls
- PCtoRd, PCSrc, output, 2 each, controls
- ImmSrc, output, 3, immediate format
- md_op, output, 1, bundle is a MUL/DIV op
- md_busy, output, 1, multi-cycle wait in progress
- illegal, output, 1, unrecognised opcode (see optional feature)

Behaviour:
- Reset: the interface is fixed as one clock, with reset synchronous and active-high. On reset, all registered outputs go to 0, state goes to IDLE, and the counter goes to 0. in_ready is 1 in the first cycle after reset.
- Bundle order: {RegWrite,ImmSrc,ALUSrc,ALUOp,ALUAdd,StoreOp,LoadOp,ResultSrc,PCtoRd,PCSrc,Branch}. Don't-cares are driven 0.
  - 0110011 OP: 100000000000000
  - 0010011 shift (funct3 001/101): 110110000000000
  - 0010011 other: 100011000000000
  - 0100011 store: 000110110000000
  - 0000011 load: 100010101100000
  - 1100011 branch: 001000000000011
  - 1100111 JALR: 100010100001100
  - 1101111 JAL: 110000000001010
  - 0110111 LUI: 101100000010000
  - 0010111 AUIPC: 101100000011000
  - Any other opcode: all zero
- M-ext: opcode 0110011, funct7=0000001, M_EXT=1 → OP bundle with md_op=1.
- States: IDLE (output register empty), HOLD (out_valid=1), MD_WAIT.
- in_ready = !flush && state!=MD_WAIT && (state==IDLE || out_ready).
- Accept = in_valid && in_ready. Bundle is registered on the accept edge.
  - Non-MD: next state HOLD, out_valid=1 the next cycle (latency 1).
  - MD: next state MD_WAIT, cnt=LAT-1, md_busy=1. Each cycle cnt decrements. When cnt==0 in MD_WAIT, go to HOLD. out_valid rises LAT cycles after accept; LAT=1 behaves as non-MD except md_busy is high for one cycle.
- HOLD: bundle stable while out_valid && !out_ready.
  - out_ready with no accept → IDLE.
  - out_ready with accept → back-to-back; stay HOLD with the new bundle (throughput 1/cycle).
- flush: next cycle state=IDLE, out_valid=0, md_busy=0, cnt=0. Overrides simultaneous accept, MD completion and out_ready; the in-flight bundle is dropped.
- Reset mid-MD_WAIT: same result as flush, plus all control outputs cleared.
- Counter width: $clog2(max(MUL_CYCLES,DIV_CYCLES))+1. No wrap; it saturates at 0.

Optional Feature:
- Macro: DECODE_ILLEGAL_TRAP_EN.
- Defined: unrecognised opcode → all-zero bundle, illegal=1, out_valid per normal latency. illegal is registered with the bundle and cleared by flush/reset. M-ext funct7 with M_EXT=0 is also illegal.
- Undefined: illegal tied to 0. Unrecognised opcodes pass as all-zero NOP bundles.

Test Plan:
- Reset, then out_ready=1 and instr=0x00000013 (ADDI) accepted at cycle N → out_valid at N+1, bundle 100011000000000, md_op=0.
- Back-to-back with out_ready=1: ADD, LW, SW, BEQ, JAL, LUI each one cycle → one bundle per cycle, each equal to its table vector, in_ready held at 1.
- MUL (0x02B50533) with DIV_CYCLES=16, MUL_CYCLES=2 → md_busy for 2 cycles, out_valid at N+2, md_op=1. DIVU → out_valid at N+16, in_ready=0 throughout the wait.
- Backpressure: out_ready=0 for 5 cycles with SLLI held → bundle 110110000000000 stable, in_ready=0. Release → one handshake, next instr accepted in the same cycle.
- flush asserted at cycle 7 of DIV, together with in_valid → out_valid never rises, state IDLE next cycle, in_ready=1. A subsequent ADD decodes normally.
- With DECODE_ILLEGAL_TRAP_EN defined, instr opcode 1111111 → out_valid and illegal=1, all controls 0. Without the macro, illegal=0.

Source files
------------

// File: rtl/decode_stage_v2.sv
// Registered RV32I/M decode stage: valid/ready on both sides, multi-cycle MUL/DIV stall, flush.
// Optional macro DECODE_ILLEGAL_TRAP_EN enables the registered illegal-opcode flag.
module decode_stage_v2 #(
    parameter int MUL_CYCLES = 2,
    parameter int DIV_CYCLES = 16,
    parameter int M_EXT      = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] instr,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        RegWrite,
    output logic [2:0]  ImmSrc,
    output logic        ALUSrc,
    output logic        ALUOp,
    output logic        ALUAdd,
    output logic        StoreOp,
    output logic        LoadOp,
    output logic        ResultSrc,
    output logic [1:0]  PCtoRd,
    output logic [1:0]  PCSrc,
    output logic        Branch,
    output logic        md_op,
    output logic        md_busy,
    output logic        illegal
);

    localparam int MAX_LAT = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int CW      = $clog2(MAX_LAT) + 1;
    localparam logic [CW-1:0] MUL_LOAD = CW'(MUL_CYCLES - 1);
    localparam logic [CW-1:0] DIV_LOAD = CW'(DIV_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, HOLD, MD_WAIT} state_t;

    state_t        state, state_next;
    logic [CW-1:0] cnt, cnt_next;
    logic [14:0]   ctrl_q, ctrl_dec;
    logic          md_op_q, md_dec, md_div_dec;
    logic          accept;
    logic [6:0]    opcode;
    logic [2:0]    funct3;
    logic          m_funct7;
    logic          unused_bits;

    assign opcode      = instr[6:0];
    assign funct3      = instr[14:12];
    assign m_funct7    = (instr[31:25] == 7'b0000001);
    assign unused_bits = ^{instr[24:15], instr[11:7]};

    always_comb begin
        ctrl_dec   = 15'b0;
        md_dec     = 1'b0;
        md_div_dec = funct3[2];
        case (opcode)
            7'b0110011: begin
                ctrl_dec = 15'b100000000000000;
                md_dec   = m_funct7 && (M_EXT != 0);
            end
            7'b0010011: begin
                if (funct3 == 3'b001 || funct3 == 3'b101)
                    ctrl_dec = 15'b110110000000000;
                else
                    ctrl_dec = 15'b100011000000000;
            end
            7'b0100011: ctrl_dec = 15'b000110110000000;
            7'b0000011: ctrl_dec = 15'b100010101100000;
            7'b1100011: ctrl_dec = 15'b001000000000011;
            7'b1100111: ctrl_dec = 15'b100010100001100;
            7'b1101111: ctrl_dec = 15'b110000000001010;
            7'b0110111: ctrl_dec = 15'b101100000010000;
            7'b0010111: ctrl_dec = 15'b101100000011000;
            default:    ctrl_dec = 15'b0;
        endcase
    end

    assign in_ready = !flush && (state != MD_WAIT) && ((state == IDLE) || out_ready);
    assign accept   = in_valid && in_ready;

    // The last MD_WAIT cycle (cnt==0) already presents the bundle so MD latency is exactly LAT.
    assign out_valid = (state == HOLD) || ((state == MD_WAIT) && (cnt == '0));
    assign md_busy   = (state == MD_WAIT);

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = md_dec ? MD_WAIT : HOLD;
                    cnt_next   = md_dec ? (md_div_dec ? DIV_LOAD : MUL_LOAD) : '0;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    if (accept) begin
                        state_next = md_dec ? MD_WAIT : HOLD;
                        cnt_next   = md_dec ? (md_div_dec ? DIV_LOAD : MUL_LOAD) : '0;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            MD_WAIT: begin
                if (cnt == '0)
                    state_next = out_ready ? IDLE : HOLD;
                else
                    cnt_next = cnt - 1'b1;
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
        if (flush) begin
            state_next = IDLE;
            cnt_next   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            ctrl_q  <= '0;
            md_op_q <= 1'b0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            if (accept) begin
                ctrl_q  <= ctrl_dec;
                md_op_q <= md_dec;
            end
        end
    end

    assign {RegWrite, ImmSrc, ALUSrc, ALUOp, ALUAdd, StoreOp, LoadOp, ResultSrc,
            PCtoRd, PCSrc, Branch} = ctrl_q;
    assign md_op = md_op_q;

`ifdef DECODE_ILLEGAL_TRAP_EN
    logic known_op, illegal_dec, illegal_q;

    always_comb begin
        case (opcode)
            7'b0110011, 7'b0010011, 7'b0100011, 7'b0000011, 7'b1100011,
            7'b1100111, 7'b1101111, 7'b0110111, 7'b0010111: known_op = 1'b1;
            default:                                        known_op = 1'b0;
        endcase
        illegal_dec = !known_op || ((opcode == 7'b0110011) && m_funct7 && (M_EXT == 0));
    end

    always_ff @(posedge clk) begin
        if (reset || flush)
            illegal_q <= 1'b0;
        else if (accept)
            illegal_q <= illegal_dec;
    end

    assign illegal = illegal_q;
`else
    assign illegal = 1'b0;
`endif

endmodule

// File: tb/tb_decode_stage_v2.sv
// Self-checking bench for decode_stage_v2: directed scenarios then randomized traffic
// against a timestamp-based single-slot transaction model.
module tb_decode_stage_v2;

    localparam int MUL_LAT = 2;
    localparam int DIV_LAT = 16;
    localparam int MEXT    = 1;

    logic        clk = 1'b0;
    logic        reset, flush, in_valid, out_ready;
    logic [31:0] instr;
    logic        in_ready, out_valid;
    logic        RegWrite, ALUSrc, ALUOp, ALUAdd, StoreOp, LoadOp, ResultSrc, Branch;
    logic [2:0]  ImmSrc;
    logic [1:0]  PCtoRd, PCSrc;
    logic        md_op, md_busy, illegal;

    int errors = 0;
    int checks = 0;

    // Model: at most one instruction in flight, visible from cycle slotAvail onwards.
    bit          slotFull = 1'b0;
    logic [16:0] slotVec;
    bit          slotMd;
    int          slotAvail;
    int          cyc = 0;

    decode_stage_v2 #(.MUL_CYCLES(MUL_LAT), .DIV_CYCLES(DIV_LAT), .M_EXT(MEXT)) dut (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .instr(instr), .out_valid(out_valid), .out_ready(out_ready),
        .RegWrite(RegWrite), .ImmSrc(ImmSrc), .ALUSrc(ALUSrc), .ALUOp(ALUOp), .ALUAdd(ALUAdd),
        .StoreOp(StoreOp), .LoadOp(LoadOp), .ResultSrc(ResultSrc), .PCtoRd(PCtoRd),
        .PCSrc(PCSrc), .Branch(Branch), .md_op(md_op), .md_busy(md_busy), .illegal(illegal)
    );

    always #5 clk = ~clk;

    function automatic logic [16:0] expVec(input logic [31:0] ins);
        logic [14:0] b;
        logic        md, ill;
        md  = 1'b0;
        ill = 1'b0;
        case (ins[6:0])
            7'b0110011: begin
                b = 15'b100000000000000;
                if (ins[31:25] == 7'b0000001) begin
                    if (MEXT != 0) md = 1'b1;
                    else ill = 1'b1;
                end
            end
            7'b0010011: b = (ins[14:12] == 3'b001 || ins[14:12] == 3'b101) ?
                            15'b110110000000000 : 15'b100011000000000;
            7'b0100011: b = 15'b000110110000000;
            7'b0000011: b = 15'b100010101100000;
            7'b1100011: b = 15'b001000000000011;
            7'b1100111: b = 15'b100010100001100;
            7'b1101111: b = 15'b110000000001010;
            7'b0110111: b = 15'b101100000010000;
            7'b0010111: b = 15'b101100000011000;
            default: begin
                b   = 15'b0;
                ill = 1'b1;
            end
        endcase
`ifndef DECODE_ILLEGAL_TRAP_EN
        ill = 1'b0;
`endif
        return {ill, md, b};
    endfunction

    function automatic int expLat(input logic [31:0] ins);
        logic [16:0] v;
        v = expVec(ins);
        if (!v[15]) return 1;
        return ins[14] ? DIV_LAT : MUL_LAT;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s cycle %0d: got %h expected %h", tag, cyc, act, exp);
        end
    endtask

    // One clock: drive at negedge, compare after settling, then advance the model at posedge.
    task automatic applyStimulus(input bit rst, input bit fl, input bit iv,
                                 input logic [31:0] ins, input bit ordy);
        bit expOv, expIr, expBusy;
        @(negedge clk);
        reset     = rst;
        flush     = fl;
        in_valid  = iv;
        instr     = ins;
        out_ready = ordy;
        #1;
        expOv   = slotFull && (cyc >= slotAvail);
        expBusy = slotFull && slotMd && (cyc <= slotAvail);
        expIr   = !fl && (!slotFull || (expOv && ordy && !(slotMd && cyc == slotAvail)));
        if (!rst) begin
            checkOutput("out_valid", {31'b0, out_valid}, {31'b0, expOv});
            checkOutput("in_ready", {31'b0, in_ready}, {31'b0, expIr});
            checkOutput("md_busy", {31'b0, md_busy}, {31'b0, expBusy});
            if (expOv)
                checkOutput("bundle", {15'b0, illegal, md_op, RegWrite, ImmSrc, ALUSrc, ALUOp,
                            ALUAdd, StoreOp, LoadOp, ResultSrc, PCtoRd, PCSrc, Branch},
                            {15'b0, slotVec});
        end
        @(posedge clk);
        if (rst || fl) begin
            slotFull = 1'b0;
        end else begin
            if (expOv && ordy) slotFull = 1'b0;
            if (iv && expIr) begin
                slotFull  = 1'b1;
                slotVec   = expVec(ins);
                slotMd    = slotVec[15];
                slotAvail = cyc + expLat(ins);
            end
        end
        cyc++;
    endtask

    function automatic logic [31:0] randInstr();
        logic [31:0] r;
        logic [6:0]  ops [10];
        int          k;
        ops = '{7'b0110011, 7'b0010011, 7'b0100011, 7'b0000011, 7'b1100011,
                7'b1100111, 7'b1101111, 7'b0110111, 7'b0010111, 7'b0110011};
        r = $urandom;
        k = $urandom_range(0, 10);
        if (k < 10) r[6:0] = ops[k];
        if (r[6:0] == 7'b0110011) begin
            case ($urandom_range(0, 2))
                0:       r[31:25] = 7'h00;
                1:       r[31:25] = 7'h01;
                default: r[31:25] = 7'h20;
            endcase
        end
        return r;
    endfunction

    initial begin
        logic [31:0] seq [6];
        seq = '{32'h00B50533, 32'h0005A503, 32'h00A5A023, 32'h00B50463, 32'h008000EF, 32'h000125B7};

        applyStimulus(1, 0, 0, 32'h0, 1);
        applyStimulus(1, 0, 0, 32'h0, 1);
        applyStimulus(0, 0, 0, 32'h0, 1);
        checkOutput("reset_bundle", {15'b0, illegal, md_op, RegWrite, ImmSrc, ALUSrc, ALUOp,
                    ALUAdd, StoreOp, LoadOp, ResultSrc, PCtoRd, PCSrc, Branch}, 32'h0);

        applyStimulus(0, 0, 1, 32'h00000013, 1);
        foreach (seq[i]) applyStimulus(0, 0, 1, seq[i], 1);
        applyStimulus(0, 0, 0, 32'h0, 1);

        applyStimulus(0, 0, 1, 32'h02B50533, 1);
        repeat (3) applyStimulus(0, 0, 0, 32'h0, 1);
        applyStimulus(0, 0, 1, 32'h02B55533, 1);
        repeat (17) applyStimulus(0, 0, 1, 32'h00000013, 1);
        applyStimulus(0, 0, 0, 32'h0, 1);

        applyStimulus(0, 0, 1, 32'h00151513, 0);
        repeat (5) applyStimulus(0, 0, 1, 32'h00B50533, 0);
        applyStimulus(0, 0, 1, 32'h00B50533, 1);
        applyStimulus(0, 0, 0, 32'h0, 1);

        applyStimulus(0, 0, 1, 32'h02B54533, 1);
        repeat (6) applyStimulus(0, 0, 0, 32'h0, 1);
        applyStimulus(0, 1, 1, 32'h00B50533, 1);
        repeat (12) applyStimulus(0, 0, 0, 32'h0, 1);
        applyStimulus(0, 0, 1, 32'h00B50533, 1);
        applyStimulus(0, 0, 0, 32'h0, 1);

        applyStimulus(0, 0, 1, 32'h0000007F, 1);
        applyStimulus(0, 0, 0, 32'h0, 1);

        for (int n = 0; n < 3000; n++) begin
            applyStimulus(($urandom_range(0, 299) == 0), ($urandom_range(0, 19) == 0),
                          ($urandom_range(0, 3) != 0), randInstr(), ($urandom_range(0, 3) != 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
